regs_wb_ctrl: RTL

Writeback controller for the integer register file's single write port. Arbitrates round-robin between the execute-stage writeback and the load/store-unit writeback, registers the winner onto the register-file write port, and keeps a 32-bit busy scoreboard so the decode stage can stall on read-after-write hazards against in-flight results. Sits between the EX/MEM stages and the `regs` write port. Decode reads `regs` combinationally alongside the `hazard` output.

---
 rtl/regs_pkg.sv | 13 +
 rtl/regs_wb_ctrl_if.sv | 45 ++++
 rtl/regs_scoreboard.sv | 42 ++++
 rtl/regs_wb_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// Shared widths and types for the integer register-file writeback path.
package regs_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef enum logic {
    WB_EX  = 1'b0,
    WB_MEM = 1'b1
  } wb_src_t;

endpackage

// File: rtl/regs_wb_ctrl_if.sv
// Bundle of the two writeback sources, the decode scoreboard hooks and the regs write port.
interface regs_wb_ctrl_if;
  import regs_pkg::*;

  // Handshake: a source raises valid with rd/data and holds all three stable until
  // it sees ready; a transfer happens on an edge where valid && ready, and ready is
  // never asserted without the matching valid.
  logic              ex_valid;
  logic              ex_ready;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_data;

  logic              sb_set;
  logic [REG_AW-1:0] sb_rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              hazard;
  logic [NREGS-1:0]  busy;

  logic              w_en;
  logic [REG_AW-1:0] waddr;
  logic [XLEN-1:0]   wdata;

  modport master (
    output ex_valid, ex_rd, ex_data,
    output mem_valid, mem_rd, mem_data,
    output sb_set, sb_rd, rs1, rs2,
    input  ex_ready, mem_ready, hazard, busy,
    input  w_en, waddr, wdata
  );

  modport slave (
    input  ex_valid, ex_rd, ex_data,
    input  mem_valid, mem_rd, mem_data,
    input  sb_set, sb_rd, rs1, rs2,
    output ex_ready, mem_ready, hazard, busy,
    output w_en, waddr, wdata
  );

endinterface

// File: rtl/regs_scoreboard.sv
// Busy bit per architectural register: set at issue, cleared when regs commits the write.
module regs_scoreboard
  import regs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic [NREGS-1:0]  busy,
  output logic              hazard
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Clear is applied first so a same-edge set of the same index wins; x0 is never marked.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_rd] = 1'b0;
    end
    if (set_en && (set_rd != '0)) begin
      busy_d[set_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign hazard = busy_q[rs1] | busy_q[rs2];

endmodule

// File: rtl/regs_wb_ctrl.sv
// Round-robin arbiter between EX and LSU writebacks feeding the single regs write port.
module regs_wb_ctrl
  import regs_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  regs_wb_ctrl_if.slave  bus
);

  logic              last_mem_q;
  logic              last_mem_d;
  logic              w_en_q;
  logic              w_en_d;
  logic [REG_AW-1:0] waddr_q;
  logic [REG_AW-1:0] waddr_d;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   wdata_d;

  logic              grant;
  wb_src_t           grant_src;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  // On a tie the source that did not win last time gets the port.
  always_comb begin
    grant     = 1'b0;
    grant_src = WB_EX;
    if (!rst) begin
      if (bus.ex_valid && bus.mem_valid) begin
        grant     = 1'b1;
        grant_src = last_mem_q ? WB_EX : WB_MEM;
      end else if (bus.mem_valid) begin
        grant     = 1'b1;
        grant_src = WB_MEM;
      end else if (bus.ex_valid) begin
        grant     = 1'b1;
        grant_src = WB_EX;
      end
    end
  end

  assign bus.ex_ready  = grant && (grant_src == WB_EX);
  assign bus.mem_ready = grant && (grant_src == WB_MEM);

  always_comb begin
    sel_rd   = bus.ex_rd;
    sel_data = bus.ex_data;
    if (grant_src == WB_MEM) begin
      sel_rd   = bus.mem_rd;
      sel_data = bus.mem_data;
    end
  end

  // x0 writes are accepted upstream but never reach regs.
  always_comb begin
    last_mem_d = last_mem_q;
    if (grant) begin
      last_mem_d = (grant_src == WB_MEM);
    end
    w_en_d  = grant && (sel_rd != '0);
    waddr_d = sel_rd;
    wdata_d = sel_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_mem_q <= 1'b0;
      w_en_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      last_mem_q <= last_mem_d;
      w_en_q     <= w_en_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.w_en  = w_en_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;

  regs_scoreboard u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set_en (bus.sb_set),
    .set_rd (bus.sb_rd),
    .clr_en (w_en_q),
    .clr_rd (waddr_q),
    .rs1    (bus.rs1),
    .rs2    (bus.rs2),
    .busy   (bus.busy),
    .hazard (bus.hazard)
  );

endmodule
